// File: rtl/slicer_ber_checker_pkg.sv
// slicer_ber_checker_pkg: shared FSM encoding, PRBS9 taps, window length and default seeds
package slicer_ber_checker_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_LOCK} state_e;
  localparam int PRBS_TAP_HI = 8;
  localparam int PRBS_TAP_LO = 4;
  localparam int WIN_LEN = 511;
  localparam logic [8:0] WIN_LAST = 9'(WIN_LEN - 1);
  localparam logic [8:0] MAX_LAT = 9'd510;
  localparam logic [8:0] DEF_SEED_I = 9'h1AA;
  localparam logic [8:0] DEF_SEED_Q = 9'h1FE;
endpackage

// File: rtl/prbs9_gen.sv
// prbs9_gen: x^9+x^5+1 Fibonacci LFSR, MSB is the emitted bit, reloadable with its seed
module prbs9_gen
  import slicer_ber_checker_pkg::*;
#(
  parameter logic [8:0] SEED = DEF_SEED_I
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_bit
);
  logic [8:0] lfsr_q, lfsr_d;
  always_comb
    lfsr_d = i_load ? SEED
           : i_en   ? {lfsr_q[7:0], lfsr_q[PRBS_TAP_HI] ^ lfsr_q[PRBS_TAP_LO]}
           : lfsr_q;
  always_ff @(posedge clk or negedge i_reset)
    if (!i_reset) lfsr_q <= SEED;
    else lfsr_q <= lfsr_d;
  assign o_bit = lfsr_q[8];
endmodule

// File: rtl/slicer_ber_checker.sv
// slicer_ber_checker: sign slicer + PRBS9 latency search on I, then saturating I/Q BER counters
module slicer_ber_checker
  import slicer_ber_checker_pkg::*;
#(
  parameter int         NBT_IN  = 12,
  parameter int         NBF_IN  = 9,
  parameter logic [8:0] SEED_I  = DEF_SEED_I,
  parameter logic [8:0] SEED_Q  = DEF_SEED_Q,
  parameter int         NBT_CNT = 64
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [NBT_IN-1:0]  i_os_data_I,
  input  logic [NBT_IN-1:0]  i_os_data_Q,
  input  logic               i_en_rate1,
  input  logic               i_enable,
  output logic               o_locked,
  output logic [8:0]         o_latency,
  output logic [NBT_CNT-1:0] o_bit_cnt,
  output logic [NBT_CNT-1:0] o_err_cnt_I,
  output logic [NBT_CNT-1:0] o_err_cnt_Q
);
  state_e state_q, state_d;
  logic [8:0] cand_q, cand_d, win_q, win_d, lat_q, lat_d;
  logic werr_q, werr_d, locked_q, locked_d;
  logic [NBT_CNT-1:0] bit_q, bit_d, erri_q, erri_d, errq_q, errq_d;
  logic [509:0] hist_i_q, hist_i_d, hist_q_q, hist_q_d;
  logic p_i, p_q, start, adv, mis_i, mis_q;
  logic [510:0] ext_i, ext_q;
  logic [8:0] sel;
  logic unused_ok;
  assign unused_ok = ^{NBF_IN[0], i_os_data_I[NBT_IN-2:0], i_os_data_Q[NBT_IN-2:0]};
  assign start = i_enable && state_q == ST_IDLE;
  assign adv = i_enable && i_en_rate1 && state_q != ST_IDLE;
  prbs9_gen #(.SEED(SEED_I)) u_prbs_i (.clk(clk), .i_reset(i_reset), .i_load(start), .i_en(adv), .o_bit(p_i));
  prbs9_gen #(.SEED(SEED_Q)) u_prbs_q (.clk(clk), .i_reset(i_reset), .i_load(start), .i_en(adv), .o_bit(p_q));
  // Index 0 is the current PRBS bit, index L the bit emitted L strobes earlier
  assign ext_i = {hist_i_q, p_i};
  assign ext_q = {hist_q_q, p_q};
  assign sel = state_q == ST_LOCK ? lat_q : cand_q;
  assign mis_i = i_os_data_I[NBT_IN-1] ^ ext_i[sel];
  assign mis_q = i_os_data_Q[NBT_IN-1] ^ ext_q[sel];
  always_comb begin
    state_d = state_q;
    cand_d = cand_q;
    win_d = win_q;
    werr_d = werr_q;
    lat_d = lat_q;
    locked_d = locked_q;
    bit_d = bit_q;
    erri_d = erri_q;
    errq_d = errq_q;
    hist_i_d = hist_i_q;
    hist_q_d = hist_q_q;
    if (!i_enable) begin
      state_d = ST_IDLE;
      locked_d = 1'b0;
    end else if (start) begin
      state_d = ST_SEARCH;
      cand_d = '0;
      win_d = '0;
      werr_d = 1'b0;
      lat_d = '0;
      locked_d = 1'b0;
      bit_d = '0;
      erri_d = '0;
      errq_d = '0;
      hist_i_d = '0;
      hist_q_d = '0;
    end else if (i_en_rate1) begin
      hist_i_d = {hist_i_q[508:0], p_i};
      hist_q_d = {hist_q_q[508:0], p_q};
      if (state_q == ST_SEARCH) begin
        win_d = win_q == WIN_LAST ? '0 : win_q + 9'd1;
        werr_d = win_q == WIN_LAST ? 1'b0 : werr_q | mis_i;
        if (win_q == WIN_LAST && !werr_q && !mis_i) begin
          state_d = ST_LOCK;
          lat_d = cand_q;
          locked_d = 1'b1;
        end else if (win_q == WIN_LAST)
          cand_d = cand_q == MAX_LAT ? '0 : cand_q + 9'd1;
      end else begin
        bit_d = &bit_q ? bit_q : bit_q + NBT_CNT'(1);
        erri_d = (mis_i && !(&erri_q)) ? erri_q + NBT_CNT'(1) : erri_q;
        errq_d = (mis_q && !(&errq_q)) ? errq_q + NBT_CNT'(1) : errq_q;
      end
    end
  end
  always_ff @(posedge clk or negedge i_reset)
    if (!i_reset) begin
      state_q <= ST_IDLE;
      cand_q <= '0;
      win_q <= '0;
      werr_q <= 1'b0;
      lat_q <= '0;
      locked_q <= 1'b0;
      bit_q <= '0;
      erri_q <= '0;
      errq_q <= '0;
      hist_i_q <= '0;
      hist_q_q <= '0;
    end else begin
      state_q <= state_d;
      cand_q <= cand_d;
      win_q <= win_d;
      werr_q <= werr_d;
      lat_q <= lat_d;
      locked_q <= locked_d;
      bit_q <= bit_d;
      erri_q <= erri_d;
      errq_q <= errq_d;
      hist_i_q <= hist_i_d;
      hist_q_q <= hist_q_d;
    end
  assign o_locked = locked_q;
  assign o_latency = lat_q;
  assign o_bit_cnt = bit_q;
  assign o_err_cnt_I = erri_q;
  assign o_err_cnt_Q = errq_q;
endmodule
